// File: rtl/cva6_su_model_core.sv
// Store-unit model: a one-entry acceptance stage feeding a speculative FIFO,
// which commit_i drains into a commit FIFO that memory responses retire.
module cva6_su_model_core #(
    parameter int unsigned SPEC_DEPTH   = 4,
    parameter int unsigned COMMIT_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        commit_i,
    input  logic        store_mem_resp_i,
    output logic        instr_ready_o,
    output logic        pop_st_o,
    output logic        valid_o,
    output logic        commit_ready_o,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    output logic [2:0]  spec_count_o,
    output logic [2:0]  commit_count_o,
    output logic        no_st_pending_o,
    output logic        store_buffer_empty_o
);

    localparam int unsigned SPW = (SPEC_DEPTH > 1) ? $clog2(SPEC_DEPTH) : 1;
    localparam int unsigned CPW = (COMMIT_DEPTH > 1) ? $clog2(COMMIT_DEPTH) : 1;

    logic           stage_valid;
    logic [31:0]    stage_addr;

    logic [31:0]    spec_q [SPEC_DEPTH];
    logic [SPW-1:0] spec_rptr, spec_wptr;
    logic [2:0]     spec_count;

    logic [31:0]    commit_q [COMMIT_DEPTH];
    logic [CPW-1:0] commit_rptr, commit_wptr;
    logic [2:0]     commit_count;

    logic           commit_fire;
    logic           resp_fire;

    function automatic logic [SPW-1:0] spec_inc(input logic [SPW-1:0] p);
        return (p == SPW'(SPEC_DEPTH - 1)) ? '0 : p + SPW'(1);
    endfunction

    function automatic logic [CPW-1:0] commit_inc(input logic [CPW-1:0] p);
        return (p == CPW'(COMMIT_DEPTH - 1)) ? '0 : p + CPW'(1);
    endfunction

    // The staged entry reserves a speculative slot, so the tail write never overflows.
    always_comb begin
        instr_ready_o  = ({1'b0, spec_count} + {3'b000, stage_valid}) < 4'(SPEC_DEPTH);
        pop_st_o       = instr_valid_i && instr_ready_o;
        commit_ready_o = {1'b0, commit_count} < 4'(COMMIT_DEPTH);
        commit_fire    = commit_i && (spec_count != 3'd0) && commit_ready_o;
        resp_fire      = store_mem_resp_i && (commit_count != 3'd0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
        end else begin
            stage_valid <= pop_st_o;
            if (pop_st_o) stage_addr <= instr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SPEC_DEPTH; i++) spec_q[i] <= '0;
            spec_rptr  <= '0;
            spec_wptr  <= '0;
            spec_count <= '0;
        end else begin
            if (stage_valid) begin
                spec_q[spec_wptr] <= stage_addr;
                spec_wptr         <= spec_inc(spec_wptr);
            end
            if (commit_fire) spec_rptr <= spec_inc(spec_rptr);
            case ({stage_valid, commit_fire})
                2'b10:   spec_count <= spec_count + 3'd1;
                2'b01:   spec_count <= spec_count - 3'd1;
                default: spec_count <= spec_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < COMMIT_DEPTH; i++) commit_q[i] <= '0;
            commit_rptr  <= '0;
            commit_wptr  <= '0;
            commit_count <= '0;
        end else begin
            if (commit_fire) begin
                commit_q[commit_wptr] <= spec_q[spec_rptr];
                commit_wptr           <= commit_inc(commit_wptr);
            end
            if (resp_fire) commit_rptr <= commit_inc(commit_rptr);
            case ({commit_fire, resp_fire})
                2'b10:   commit_count <= commit_count + 3'd1;
                2'b01:   commit_count <= commit_count - 3'd1;
                default: commit_count <= commit_count;
            endcase
        end
    end

    always_comb begin
        valid_o              = stage_valid;
        req_valid_o          = commit_count != 3'd0;
        req_addr_o           = (commit_count != 3'd0) ? commit_q[commit_rptr] : '0;
        spec_count_o         = spec_count;
        commit_count_o       = commit_count;
        no_st_pending_o      = !stage_valid && (spec_count == 3'd0) && (commit_count == 3'd0);
        store_buffer_empty_o = commit_count == 3'd0;
    end

endmodule

// File: tb/tb_cva6_su_model_core.sv
// Directed self-checking bench for cva6_su_model_core with hand-computed expectations.
module tb_cva6_su_model_core;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        commit_i;
    logic        store_mem_resp_i;
    logic        instr_ready_o;
    logic        pop_st_o;
    logic        valid_o;
    logic        commit_ready_o;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic [2:0]  spec_count_o;
    logic [2:0]  commit_count_o;
    logic        no_st_pending_o;
    logic        store_buffer_empty_o;

    int n_cmp = 0;
    int n_err = 0;

    cva6_su_model_core #(.SPEC_DEPTH(4), .COMMIT_DEPTH(4)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .instr_i             (instr_i),
        .instr_valid_i       (instr_valid_i),
        .commit_i            (commit_i),
        .store_mem_resp_i    (store_mem_resp_i),
        .instr_ready_o       (instr_ready_o),
        .pop_st_o            (pop_st_o),
        .valid_o             (valid_o),
        .commit_ready_o      (commit_ready_o),
        .req_valid_o         (req_valid_o),
        .req_addr_o          (req_addr_o),
        .spec_count_o        (spec_count_o),
        .commit_count_o      (commit_count_o),
        .no_st_pending_o     (no_st_pending_o),
        .store_buffer_empty_o(store_buffer_empty_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; instr_valid_i = 1'b1; instr_i = 32'hDEAD_BEEF;
        commit_i = 1'b1; store_mem_resp_i = 1'b1;
        #1;
        n_cmp++; if (instr_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", instr_ready_o); end
        n_cmp++; if (pop_st_o !== 1'b1) begin n_err++; $display("FAIL rst_pop: got %b expected 1", pop_st_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
        n_cmp++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b expected 0", req_valid_o); end
        n_cmp++; if (req_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_req_addr: got %h expected 0", req_addr_o); end
        n_cmp++; if (no_st_pending_o !== 1'b1) begin n_err++; $display("FAIL rst_nopend: got %b expected 1", no_st_pending_o); end
        n_cmp++; if (store_buffer_empty_o !== 1'b1) begin n_err++; $display("FAIL rst_sbe: got %b expected 1", store_buffer_empty_o); end
        n_cmp++; if (commit_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_commit_ready: got %b expected 1", commit_ready_o); end
        tick(); tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid: got %b expected 0", valid_o); end
        n_cmp++; if (spec_count_o !== 3'd0) begin n_err++; $display("FAIL rst_hold_spec: got %0d expected 0", spec_count_o); end
        n_cmp++; if (commit_count_o !== 3'd0) begin n_err++; $display("FAIL rst_hold_commit: got %0d expected 0", commit_count_o); end
        instr_valid_i = 1'b0; commit_i = 1'b0; store_mem_resp_i = 1'b0; instr_i = '0;
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        instr_valid_i = 1'b1; instr_i = 32'h1234_5678;
        #1;
        n_cmp++; if (pop_st_o !== 1'b1) begin n_err++; $display("FAIL single_pop: got %b expected 1", pop_st_o); end
        tick();
        instr_valid_i = 1'b0;
        n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", valid_o); end
        n_cmp++; if (spec_count_o !== 3'd0) begin n_err++; $display("FAIL single_spec_c1: got %0d expected 0", spec_count_o); end
        tick();
        n_cmp++; if (spec_count_o !== 3'd1) begin n_err++; $display("FAIL single_spec_c2: got %0d expected 1", spec_count_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_c2: got %b expected 0", valid_o); end
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        n_cmp++; if (req_valid_o !== 1'b1) begin n_err++; $display("FAIL single_req_valid: got %b expected 1", req_valid_o); end
        n_cmp++; if (req_addr_o !== 32'h1234_5678) begin n_err++; $display("FAIL single_req_addr: got %h expected 12345678", req_addr_o); end
        n_cmp++; if (store_buffer_empty_o !== 1'b0) begin n_err++; $display("FAIL single_sbe: got %b expected 0", store_buffer_empty_o); end
        n_cmp++; if (no_st_pending_o !== 1'b0) begin n_err++; $display("FAIL single_pend_c3: got %b expected 0", no_st_pending_o); end
        store_mem_resp_i = 1'b1;
        tick();
        store_mem_resp_i = 1'b0;
        n_cmp++; if (no_st_pending_o !== 1'b1) begin n_err++; $display("FAIL single_nopend: got %b expected 1", no_st_pending_o); end
        n_cmp++; if (req_addr_o !== 32'h0) begin n_err++; $display("FAIL single_addr_empty: got %h expected 0", req_addr_o); end
    endtask

    task automatic test_spec_full();
        for (int i = 0; i < 5; i++) begin
            instr_valid_i = 1'b1; instr_i = 32'hA000_0000 + 32'(i);
            #1;
            if (i < 4) begin
                n_cmp++; if (pop_st_o !== 1'b1) begin n_err++; $display("FAIL spec_full_pop%0d: got %b expected 1", i, pop_st_o); end
            end else begin
                n_cmp++; if (pop_st_o !== 1'b0) begin n_err++; $display("FAIL spec_full_pop5: got %b expected 0", pop_st_o); end
                n_cmp++; if (instr_ready_o !== 1'b0) begin n_err++; $display("FAIL spec_full_ready5: got %b expected 0", instr_ready_o); end
            end
            tick();
        end
        instr_valid_i = 1'b0;
        n_cmp++; if (spec_count_o !== 3'd4) begin n_err++; $display("FAIL spec_full_count: got %0d expected 4", spec_count_o); end
        n_cmp++; if (instr_ready_o !== 1'b0) begin n_err++; $display("FAIL spec_full_ready: got %b expected 0", instr_ready_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL spec_full_stage: got %b expected 0", valid_o); end
    endtask

    task automatic test_commit_full();
        commit_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        commit_i = 1'b0;
        n_cmp++; if (commit_count_o !== 3'd4) begin n_err++; $display("FAIL cfull_count: got %0d expected 4", commit_count_o); end
        n_cmp++; if (spec_count_o !== 3'd0) begin n_err++; $display("FAIL cfull_spec: got %0d expected 0", spec_count_o); end
        n_cmp++; if (commit_ready_o !== 1'b0) begin n_err++; $display("FAIL cfull_ready: got %b expected 0", commit_ready_o); end
        n_cmp++; if (req_addr_o !== 32'hA000_0000) begin n_err++; $display("FAIL cfull_head: got %h expected a0000000", req_addr_o); end
        instr_valid_i = 1'b1; instr_i = 32'hA000_0004;
        tick();
        instr_valid_i = 1'b0;
        tick();
        n_cmp++; if (spec_count_o !== 3'd1) begin n_err++; $display("FAIL cfull_push: got %0d expected 1", spec_count_o); end
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        n_cmp++; if (spec_count_o !== 3'd1) begin n_err++; $display("FAIL cfull_reject_spec: got %0d expected 1", spec_count_o); end
        n_cmp++; if (commit_count_o !== 3'd4) begin n_err++; $display("FAIL cfull_reject_commit: got %0d expected 4", commit_count_o); end
        // A response freeing a slot in the same cycle must not let the commit in.
        commit_i = 1'b1; store_mem_resp_i = 1'b1;
        tick();
        commit_i = 1'b0; store_mem_resp_i = 1'b0;
        n_cmp++; if (commit_count_o !== 3'd3) begin n_err++; $display("FAIL cfull_resp_count: got %0d expected 3", commit_count_o); end
        n_cmp++; if (spec_count_o !== 3'd1) begin n_err++; $display("FAIL cfull_resp_spec: got %0d expected 1", spec_count_o); end
        n_cmp++; if (req_addr_o !== 32'hA000_0001) begin n_err++; $display("FAIL cfull_resp_head: got %h expected a0000001", req_addr_o); end
    endtask

    task automatic test_simultaneous();
        store_mem_resp_i = 1'b1;
        tick();
        store_mem_resp_i = 1'b0;
        n_cmp++; if (commit_count_o !== 3'd2) begin n_err++; $display("FAIL sim_pre_count: got %0d expected 2", commit_count_o); end
        n_cmp++; if (req_addr_o !== 32'hA000_0002) begin n_err++; $display("FAIL sim_pre_head: got %h expected a0000002", req_addr_o); end
        commit_i = 1'b1; store_mem_resp_i = 1'b1;
        tick();
        commit_i = 1'b0; store_mem_resp_i = 1'b0;
        n_cmp++; if (commit_count_o !== 3'd2) begin n_err++; $display("FAIL sim_count: got %0d expected 2", commit_count_o); end
        n_cmp++; if (spec_count_o !== 3'd0) begin n_err++; $display("FAIL sim_spec: got %0d expected 0", spec_count_o); end
        n_cmp++; if (req_addr_o !== 32'hA000_0003) begin n_err++; $display("FAIL sim_head: got %h expected a0000003", req_addr_o); end
        store_mem_resp_i = 1'b1;
        tick();
        n_cmp++; if (req_addr_o !== 32'hA000_0004) begin n_err++; $display("FAIL sim_head2: got %h expected a0000004", req_addr_o); end
        tick();
        store_mem_resp_i = 1'b0;
        n_cmp++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL sim_drain_valid: got %b expected 0", req_valid_o); end
        n_cmp++; if (no_st_pending_o !== 1'b1) begin n_err++; $display("FAIL sim_drain_nopend: got %b expected 1", no_st_pending_o); end
    endtask

    task automatic test_back_to_back();
        instr_valid_i = 1'b1; instr_i = 32'hB000_0000;
        tick();
        instr_i = 32'hB000_0001;
        tick();
        instr_valid_i = 1'b0;
        n_cmp++; if (spec_count_o !== 3'd1) begin n_err++; $display("FAIL b2b_spec_pre: got %0d expected 1", spec_count_o); end
        n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_stage: got %b expected 1", valid_o); end
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        n_cmp++; if (spec_count_o !== 3'd1) begin n_err++; $display("FAIL b2b_spec_same: got %0d expected 1", spec_count_o); end
        n_cmp++; if (commit_count_o !== 3'd1) begin n_err++; $display("FAIL b2b_commit: got %0d expected 1", commit_count_o); end
        n_cmp++; if (req_addr_o !== 32'hB000_0000) begin n_err++; $display("FAIL b2b_head: got %h expected b0000000", req_addr_o); end
        commit_i = 1'b1; store_mem_resp_i = 1'b1;
        tick();
        commit_i = 1'b0;
        n_cmp++; if (req_addr_o !== 32'hB000_0001) begin n_err++; $display("FAIL b2b_head2: got %h expected b0000001", req_addr_o); end
        tick();
        store_mem_resp_i = 1'b0;
        n_cmp++; if (no_st_pending_o !== 1'b1) begin n_err++; $display("FAIL b2b_nopend: got %b expected 1", no_st_pending_o); end
    endtask

    task automatic test_spurious();
        commit_i = 1'b1; store_mem_resp_i = 1'b1;
        tick(); tick();
        commit_i = 1'b0; store_mem_resp_i = 1'b0;
        n_cmp++; if (spec_count_o !== 3'd0) begin n_err++; $display("FAIL spur_spec: got %0d expected 0", spec_count_o); end
        n_cmp++; if (commit_count_o !== 3'd0) begin n_err++; $display("FAIL spur_commit: got %0d expected 0", commit_count_o); end
        n_cmp++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL spur_req: got %b expected 0", req_valid_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            instr_valid_i = 1'b1; instr_i = 32'hC000_0000 + 32'(i);
            tick();
        end
        instr_valid_i = 1'b0;
        tick();
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        n_cmp++; if (spec_count_o !== 3'd2) begin n_err++; $display("FAIL rmid_pre_spec: got %0d expected 2", spec_count_o); end
        n_cmp++; if (commit_count_o !== 3'd1) begin n_err++; $display("FAIL rmid_pre_commit: got %0d expected 1", commit_count_o); end
        #3 rst_ni = 1'b0;
        #1;
        n_cmp++; if (spec_count_o !== 3'd0) begin n_err++; $display("FAIL rmid_spec: got %0d expected 0", spec_count_o); end
        n_cmp++; if (commit_count_o !== 3'd0) begin n_err++; $display("FAIL rmid_commit: got %0d expected 0", commit_count_o); end
        n_cmp++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %b expected 0", req_valid_o); end
        n_cmp++; if (no_st_pending_o !== 1'b1) begin n_err++; $display("FAIL rmid_nopend: got %b expected 1", no_st_pending_o); end
        tick();
        rst_ni = 1'b1;
        instr_valid_i = 1'b1; instr_i = 32'hD000_0000;
        tick();
        instr_valid_i = 1'b0;
        n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL rmid_resume_valid: got %b expected 1", valid_o); end
        tick();
        n_cmp++; if (spec_count_o !== 3'd1) begin n_err++; $display("FAIL rmid_resume_spec: got %0d expected 1", spec_count_o); end
    endtask

    initial begin
        rst_ni = 1'b0; instr_i = '0; instr_valid_i = 1'b0;
        commit_i = 1'b0; store_mem_resp_i = 1'b0;
        tick();
        test_reset();
        test_single();
        test_spec_full();
        test_commit_full();
        test_simultaneous();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
